// File: rtl/display_arbiter_if.sv
// Display arbiter bus: user/clock inputs toward the arbiter and the registered 7-seg word, mask and owner back out.
interface display_arbiter_if;
  logic        one_second;
  logic        key_valid;
  logic [15:0] key_buffer;
  logic        load_done;
  logic        show_alarm;
  logic        alarm_ring;
  logic [15:0] current_time;
  logic [15:0] alarm_time;
  logic [15:0] display_word;
  logic [3:0]  display_mask;
  logic [1:0]  source;
  logic        entry_timeout;

  modport master (
    output one_second, key_valid, key_buffer, load_done, show_alarm,
           alarm_ring, current_time, alarm_time,
    input  display_word, display_mask, source, entry_timeout
  );

  modport slave (
    input  one_second, key_valid, key_buffer, load_done, show_alarm,
           alarm_ring, current_time, alarm_time,
    output display_word, display_mask, source, entry_timeout
  );
endinterface

// File: rtl/display_arbiter.sv
// Picks which word owns the 7-seg display (time, key entry, alarm, ringing blink).
// All outputs registered, 1-cycle latency from sampled inputs; no backpressure, every input acted on the cycle it arrives.
module display_arbiter #(
  parameter int TIMEOUT_SEC = 10
) (
  input logic              clk256,
  input logic              reset,
  display_arbiter_if.slave bus
);

  localparam int IDLE_W = $clog2(TIMEOUT_SEC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_SEC - 1);

  typedef enum logic [1:0] {
    ST_TIME  = 2'b00,
    ST_KEY   = 2'b01,
    ST_ALARM = 2'b10,
    ST_RING  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [2:0]        digits_q, digits_d;
  logic [7:0]        blink_q, blink_d;
  logic [15:0]       display_word_q, display_word_d;
  logic [3:0]        display_mask_q, display_mask_d;
  logic              entry_timeout_q, entry_timeout_d;

  always_comb begin
    state_d         = ST_TIME;
    entry_timeout_d = 1'b0;
    idle_d          = '0;
    digits_d        = '0;
    blink_d         = '0;
    display_word_d  = bus.current_time;
    display_mask_d  = 4'b1111;

    // load_done beats both a new digit and an expiring idle timer
    if (state_q == ST_KEY) begin
      if (bus.load_done) begin
        state_d = ST_TIME;
      end else if (bus.key_valid) begin
        state_d = ST_KEY;
      end else if (bus.one_second && idle_q == IDLE_LAST) begin
        state_d         = ST_TIME;
        entry_timeout_d = 1'b1;
      end else begin
        state_d = ST_KEY;
      end
    end else if (bus.key_valid) begin
      state_d = ST_KEY;
    end else if (bus.alarm_ring) begin
      state_d = ST_RING;
    end else if (bus.show_alarm) begin
      state_d = ST_ALARM;
    end else begin
      state_d = ST_TIME;
    end

    case (state_d)
      ST_KEY: begin
        if (state_q != ST_KEY) begin
          idle_d   = '0;
          digits_d = 3'd1;
        end else begin
          if (bus.key_valid) begin
            idle_d   = '0;
            digits_d = (digits_q == 3'd4) ? digits_q : digits_q + 3'd1;
          end else begin
            idle_d   = bus.one_second ? idle_q + 1'b1 : idle_q;
            digits_d = digits_q;
          end
        end
        display_word_d = bus.key_buffer;
        case (digits_d)
          3'd1:    display_mask_d = 4'b0001;
          3'd2:    display_mask_d = 4'b0011;
          3'd3:    display_mask_d = 4'b0111;
          3'd4:    display_mask_d = 4'b1111;
          default: display_mask_d = 4'b0000;
        endcase
      end
      ST_ALARM: display_word_d = bus.alarm_time;
      ST_RING: begin
        blink_d        = (state_q == ST_RING) ? blink_q + 8'd1 : 8'd0;
        display_mask_d = blink_d[7] ? 4'b0000 : 4'b1111;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk256) begin
    if (reset) begin
      state_q         <= ST_TIME;
      idle_q          <= '0;
      digits_q        <= '0;
      blink_q         <= '0;
      display_word_q  <= 16'h0000;
      display_mask_q  <= 4'b1111;
      entry_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      idle_q          <= idle_d;
      digits_q        <= digits_d;
      blink_q         <= blink_d;
      display_word_q  <= display_word_d;
      display_mask_q  <= display_mask_d;
      entry_timeout_q <= entry_timeout_d;
    end
  end

  assign bus.display_word  = display_word_q;
  assign bus.display_mask  = display_mask_q;
  assign bus.source        = state_q;
  assign bus.entry_timeout = entry_timeout_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed vectors for display_arbiter with hand-computed expectations.
module tb_display_arbiter;

  logic clk256 = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  display_arbiter_if bus ();

  display_arbiter #(.TIMEOUT_SEC(10)) dut (
    .clk256 (clk256),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 clk256 = ~clk256;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk256);
    #1;
  endtask

  task automatic key_step(input logic [15:0] kb);
    bus.key_buffer = kb;
    bus.key_valid  = 1'b1;
    step();
    bus.key_valid  = 1'b0;
  endtask

  task automatic sec_step();
    bus.one_second = 1'b1;
    step();
    bus.one_second = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    bus.one_second   = 1'b0;
    bus.key_valid    = 1'b0;
    bus.key_buffer   = 16'h0000;
    bus.load_done    = 1'b0;
    bus.show_alarm   = 1'b0;
    bus.alarm_ring   = 1'b0;
    bus.current_time = 16'h1234;
    bus.alarm_time   = 16'h0630;

    step();
    check("rst_word", bus.display_word, 16'h0000);
    check("rst_mask", bus.display_mask, 4'b1111);
    check("rst_src", bus.source, 2'b00);
    check("rst_to", bus.entry_timeout, 1'b0);
    reset = 1'b0;
    step();
    check("idle_word", bus.display_word, 16'h1234);
    check("idle_mask", bus.display_mask, 4'b1111);
    check("idle_src", bus.source, 2'b00);

    // Three-digit entry then commit
    key_step(16'h0001);
    check("k1_src", bus.source, 2'b01);
    check("k1_mask", bus.display_mask, 4'b0001);
    check("k1_word", bus.display_word, 16'h0001);
    key_step(16'h0012);
    check("k2_mask", bus.display_mask, 4'b0011);
    check("k2_word", bus.display_word, 16'h0012);
    key_step(16'h0123);
    check("k3_mask", bus.display_mask, 4'b0111);
    check("k3_word", bus.display_word, 16'h0123);
    key_step(16'h1234);
    check("k4_mask", bus.display_mask, 4'b1111);
    key_step(16'h2345);
    check("k5_sat_mask", bus.display_mask, 4'b1111);
    check("k5_word", bus.display_word, 16'h2345);
    bus.key_buffer = 16'h3456;
    step();
    check("k_track_word", bus.display_word, 16'h3456);
    check("k_track_src", bus.source, 2'b01);
    bus.load_done = 1'b1;
    step();
    bus.load_done = 1'b0;
    check("ld_src", bus.source, 2'b00);
    check("ld_to", bus.entry_timeout, 1'b0);
    check("ld_word", bus.display_word, 16'h1234);
    bus.load_done = 1'b1;
    step();
    bus.load_done = 1'b0;
    check("ld_idle_src", bus.source, 2'b00);
    check("ld_idle_to", bus.entry_timeout, 1'b0);

    // Idle timeout after ten seconds
    key_step(16'h0009);
    for (int i = 1; i <= 9; i++) sec_step();
    check("to9_src", bus.source, 2'b01);
    check("to9_to", bus.entry_timeout, 1'b0);
    sec_step();
    check("to10_src", bus.source, 2'b00);
    check("to10_to", bus.entry_timeout, 1'b1);
    check("to10_word", bus.display_word, 16'h1234);
    step();
    check("to_pulse_end", bus.entry_timeout, 1'b0);

    // A digit on the 9th second restarts the idle count
    key_step(16'h0005);
    check("re_mask", bus.display_mask, 4'b0001);
    for (int i = 1; i <= 8; i++) sec_step();
    bus.one_second = 1'b1;
    key_step(16'h0056);
    bus.one_second = 1'b0;
    check("re9_src", bus.source, 2'b01);
    check("re9_mask", bus.display_mask, 4'b0011);
    for (int i = 10; i <= 18; i++) sec_step();
    check("re18_src", bus.source, 2'b01);
    check("re18_to", bus.entry_timeout, 1'b0);
    sec_step();
    check("re19_src", bus.source, 2'b00);
    check("re19_to", bus.entry_timeout, 1'b1);
    step();

    // Ringing: 128 on, 128 off, wrap
    bus.alarm_ring = 1'b1;
    step();
    check("ring_src", bus.source, 2'b11);
    check("ring_word", bus.display_word, 16'h1234);
    check("ring_mask0", bus.display_mask, 4'b1111);
    repeat (127) step();
    check("ring_mask127", bus.display_mask, 4'b1111);
    step();
    check("ring_mask128", bus.display_mask, 4'b0000);
    bus.current_time = 16'h0745;
    repeat (127) step();
    check("ring_mask255", bus.display_mask, 4'b0000);
    check("ring_word_trk", bus.display_word, 16'h0745);
    step();
    check("ring_wrap", bus.display_mask, 4'b1111);
    key_step(16'h0007);
    check("ring_key_src", bus.source, 2'b01);
    check("ring_key_word", bus.display_word, 16'h0007);
    bus.load_done = 1'b1;
    step();
    bus.load_done = 1'b0;
    check("ring_ld_src", bus.source, 2'b00);
    step();
    check("ring_again_src", bus.source, 2'b11);
    bus.alarm_ring = 1'b0;
    bus.show_alarm = 1'b1;
    step();
    check("alarm_src", bus.source, 2'b10);
    check("alarm_word", bus.display_word, 16'h0630);
    check("alarm_mask", bus.display_mask, 4'b1111);
    bus.show_alarm = 1'b0;
    step();
    check("alarm_exit_src", bus.source, 2'b00);
    check("alarm_exit_word", bus.display_word, 16'h0745);

    // load_done coincident with the expiring second
    key_step(16'h0001);
    for (int i = 1; i <= 9; i++) sec_step();
    bus.one_second = 1'b1;
    bus.load_done  = 1'b1;
    step();
    bus.one_second = 1'b0;
    bus.load_done  = 1'b0;
    check("ldto_src", bus.source, 2'b00);
    check("ldto_to", bus.entry_timeout, 1'b0);

    // Reset in the middle of an entry
    key_step(16'h0042);
    check("mid_src", bus.source, 2'b01);
    reset = 1'b1;
    step();
    check("mid_rst_src", bus.source, 2'b00);
    check("mid_rst_word", bus.display_word, 16'h0000);
    check("mid_rst_mask", bus.display_mask, 4'b1111);
    reset = 1'b0;
    step();
    check("post_rst_word", bus.display_word, 16'h0745);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_SEC, default 10, meaning idle seconds before an abandoned key entry is dropped.
REQ-002 SHALL have port clk256  input  1  system clock, 256 Hz enable-domain clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port one_second  input  1  single-cycle pulse once per second.
REQ-005 SHALL have port key_valid  input  1  single-cycle pulse, new digit accepted into key_buffer.
REQ-006 SHALL have port key_buffer  input  16  four BCD digits under entry.
REQ-007 SHALL have port load_done  input  1  single-cycle pulse, entry committed as alarm or time.
REQ-008 SHALL have port show_alarm  input  1  level, user requests alarm-time view.
REQ-009 SHALL have port alarm_ring  input  1  level, alarm currently sounding.
REQ-010 SHALL have port current_time  input  16  BCD HH:MM from the clock counter.
REQ-011 SHALL have port alarm_time  input  16  BCD HH:MM stored alarm.
REQ-012 SHALL have port display_word  output  16  word to the 7-seg driver.
REQ-013 SHALL have port display_mask  output  4  per-digit enable to the 7-seg driver, bit3 = leftmost.
REQ-014 SHALL have port source  output  2  current owner: 00 TIME, 01 KEY, 10 ALARM, 11 RING.
REQ-015 SHALL have port entry_timeout  output  1  single-cycle pulse when an entry is dropped for idleness.

Function
REQ-016 SHALL implement FSM states TIME, KEY, ALARM, RING; source SHALL equal the state encoding.
REQ-017 All outputs SHALL be registered; state, display_word, display_mask update on the clk256 edge following the sampled inputs (1-cycle latency).
REQ-018 Transition priority from TIME, ALARM, RING: key_valid -> KEY, else alarm_ring -> RING, else show_alarm -> ALARM, else TIME.
REQ-019 ALARM SHALL return to TIME when show_alarm is low and alarm_ring low; RING SHALL exit to ALARM or TIME per REQ-018 when alarm_ring falls.
REQ-020 KEY SHALL exit to TIME on load_done; load_done SHALL take precedence over timeout and over key_valid in the same cycle.
REQ-021 KEY SHALL hold an idle-second counter, width clog2(TIMEOUT_SEC+1), cleared on entering KEY and on every key_valid; key_valid clear SHALL win over a coincident one_second increment.
REQ-022 When the idle counter would reach TIMEOUT_SEC on a one_second pulse, KEY SHALL go to TIME and entry_timeout SHALL be high for exactly that one cycle.
REQ-023 KEY SHALL count digits entered (entry key_valid counts as 1), saturating at 4; display_mask SHALL be 0001, 0011, 0111, 1111 for counts 1..4.
REQ-024 display_word SHALL be current_time in TIME, key_buffer in KEY, alarm_time in ALARM, current_time in RING, tracking the source every cycle.
REQ-025 display_mask SHALL be 1111 in TIME and ALARM.
REQ-026 RING SHALL use an 8-bit blink counter cleared on entry and incremented every cycle, wrapping 255->0; display_mask = 1111 while counter bit7 = 0, else 0000 (128 cycles on, 128 off).
REQ-027 Leaving KEY for any reason SHALL clear the digit count; re-entering KEY SHALL restart it at 1.
REQ-028 load_done outside KEY SHALL be ignored; entry_timeout SHALL never assert outside a KEY->TIME exit.

Reset
REQ-029 On reset high at a clk256 edge: state TIME, display_word 16'h0000, display_mask 4'b1111, source 00, entry_timeout 0, all counters 0; reset SHALL override every other input including mid-entry and mid-blink.
REQ-030 First edge after reset deasserts SHALL load display_word with current_time.

Verification
REQ-031 Reset, current_time=16'h1234, idle -> display_word 1234, mask 1111, source 00 after 1 cycle.
REQ-032 Three key_valid pulses with key_buffer 0001,0012,0123 -> source 01, masks 0001,0011,0111, words track; load_done -> source 00, entry_timeout stays 0.
REQ-033 One key_valid then 10 one_second pulses, no keys -> TIME after the 10th pulse, entry_timeout high exactly one cycle; key_valid coincident with 9th pulse restarts count (timeout at 19th).
REQ-034 alarm_ring high in TIME -> source 11, word=current_time, mask 1111 for 128 cycles then 0000 for 128; key_valid mid-ring -> KEY; alarm_ring low with show_alarm high -> ALARM, word=alarm_time.
REQ-035 load_done and timeout pulse in same cycle -> TIME, entry_timeout 0; reset asserted mid-KEY -> TIME, word 0000, mask 1111 next edge.
